// File: rtl/bsg_sipo_arb_pkg.sv
// Shared types and helpers for the round-robin packet SIPO arbiter.
package bsg_sipo_arb_pkg;

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_collect = 2'd1,
    e_drain   = 2'd2
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_sipo_arb_rr_pick.sv
// Combinational round-robin picker: scans upward from last_i+1 (mod num_in_p).
module bsg_sipo_arb_rr_pick
  import bsg_sipo_arb_pkg::*;
#(
  parameter int unsigned num_in_p = 2,
  parameter int unsigned lg_in_lp = safe_clog2(num_in_p)
) (
  input  logic [num_in_p-1:0] req_i,
  input  logic [lg_in_lp-1:0] last_i,
  output logic [num_in_p-1:0] grant_oh_o,
  output logic [lg_in_lp-1:0] grant_idx_o,
  output logic                any_v_o
);

  always_comb begin
    int idx;
    idx         = 0;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_v_o     = 1'b0;
    for (int i = 0; i < int'(num_in_p); i++) begin
      idx = (int'(last_i) + 1 + i) % int'(num_in_p);
      if (!any_v_o && req_i[idx]) begin
        any_v_o         = 1'b1;
        grant_idx_o     = lg_in_lp'(idx);
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_sipo_packet_arbiter.sv
// Shares one full-packet SIPO assembler among num_in_p serial sources, one
// round-robin grant per packet, held for exactly els_p accepted words.
module bsg_sipo_packet_arbiter
  import bsg_sipo_arb_pkg::*;
#(
  parameter int unsigned width_p   = 8,
  parameter int unsigned els_p     = 4,
  parameter int unsigned num_in_p  = 3,
  parameter int unsigned lg_in_lp  = safe_clog2(num_in_p),
  parameter int unsigned lg_els_lp = safe_clog2(els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         v_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         ready_o,
  output logic                        v_o,
  output logic [els_p*width_p-1:0]    data_o,
  output logic [lg_in_lp-1:0]         id_o,
  input  logic                        yumi_i
);

  state_e                            state_q, state_d;
  logic [lg_els_lp-1:0]              count_q, count_d;
  logic [lg_in_lp-1:0]               lock_q, lock_d;
  logic [lg_in_lp-1:0]               last_q, last_d;
  logic [els_p-1:0][width_p-1:0]     data_q;

  logic [num_in_p-1:0]               grant_oh;
  logic [lg_in_lp-1:0]               grant_idx;
  logic                              any_v;

  logic                              wr_en;
  logic [lg_els_lp-1:0]              wr_idx;
  logic [width_p-1:0]                wr_word;

  bsg_sipo_arb_rr_pick #(
    .num_in_p (num_in_p),
    .lg_in_lp (lg_in_lp)
  ) u_pick (
    .req_i       (v_i),
    .last_i      (last_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_v_o     (any_v)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lock_d  = lock_q;
    last_d  = last_q;
    ready_o = '0;
    v_o     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_word = data_i[int'(lock_q)*width_p +: width_p];
    unique case (state_q)
      e_idle: begin
        if (any_v) begin
          ready_o = grant_oh;
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_word = data_i[int'(grant_idx)*width_p +: width_p];
          lock_d  = grant_idx;
          if (els_p == 1) begin
            state_d = e_drain;
          end else begin
            state_d = e_collect;
            count_d = lg_els_lp'(1);
          end
        end
      end
      e_collect: begin
        // Grant stays locked to one source until the packet is complete.
        ready_o[lock_q] = 1'b1;
        if (v_i[lock_q]) begin
          wr_en  = 1'b1;
          wr_idx = count_q;
          if (count_q == lg_els_lp'(els_p - 1)) begin
            state_d = e_drain;
            count_d = '0;
          end else begin
            count_d = count_q + lg_els_lp'(1);
          end
        end
      end
      e_drain: begin
        v_o = 1'b1;
        if (yumi_i) begin
          last_d  = lock_q;
          state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
    // Reset is asynchronous; keep the handshake quiet for its whole duration.
    if (reset_i) begin
      ready_o = '0;
      v_o     = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      count_q <= '0;
      lock_q  <= '0;
      last_q  <= lg_in_lp'(num_in_p - 1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_word;
    end
  end

  assign data_o = data_q;
  assign id_o   = lock_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("yumi_i asserted while v_o is low");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_sipo_packet_arbiter.sv
// Directed bench: 3-source/4-word arbiter plus a 1-source/1-word instance.
module tb_bsg_sipo_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [2:0]  v = '0;
  logic [23:0] din = '0;
  logic [2:0]  ready;
  logic        vo;
  logic [31:0] dout;
  logic [1:0]  id;
  logic        yumi;
  logic        yumi_man = 1'b0;
  logic        yumi_auto = 1'b0;

  logic [0:0]  v1 = '0;
  logic [7:0]  d1 = '0;
  logic [0:0]  r1;
  logic        vo1;
  logic [7:0]  do1;
  logic [0:0]  id1;
  logic        yumi1 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Auto mode acknowledges every presented packet the cycle it appears.
  assign yumi = yumi_auto ? vo : yumi_man;

  bsg_sipo_packet_arbiter #(
    .width_p  (8),
    .els_p    (4),
    .num_in_p (3)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .v_i     (v),
    .data_i  (din),
    .ready_o (ready),
    .v_o     (vo),
    .data_o  (dout),
    .id_o    (id),
    .yumi_i  (yumi)
  );

  bsg_sipo_packet_arbiter #(
    .width_p  (8),
    .els_p    (1),
    .num_in_p (1)
  ) dut1 (
    .clk_i   (clk),
    .reset_i (rst),
    .v_i     (v1),
    .data_i  (d1),
    .ready_o (r1),
    .v_o     (vo1),
    .data_o  (do1),
    .id_o    (id1),
    .yumi_i  (yumi1)
  );

  task automatic ack_main();
    @(negedge clk);
    yumi_man = 1'b1;
    @(negedge clk);
    yumi_man = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v   = 3'b111;
    v1  = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ready !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready got %b exp %b", ready, 3'b000);
    end
    checks++;
    if (vo !== 1'b0 || vo1 !== 1'b0 || r1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_vo got vo=%b vo1=%b r1=%b exp 0", vo, vo1, r1);
    end
    @(negedge clk);
    v   = '0;
    v1  = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_stream();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v   = 3'b010;
      din = '0;
      din[15:8] = 8'(8'hA0 + k);
      #1;
      checks++;
      if (ready !== 3'b010 || vo !== 1'b0) begin
        failures++;
        $display("FAIL stream_word%0d got ready=%b vo=%b exp ready=010 vo=0", k, ready, vo);
      end
    end
    @(negedge clk);
    v = '0;
    #1;
    checks++;
    if (vo !== 1'b1 || dout !== 32'hA3A2A1A0 || id !== 2'd1 || ready !== 3'b000) begin
      failures++;
      $display("FAIL stream_pkt got vo=%b data=%h id=%0d ready=%b exp vo=1 data=a3a2a1a0 id=1 ready=000",
               vo, dout, id, ready);
    end
    ack_main();
  endtask

  task automatic test_round_robin();
    int cnt [3];
    int pkt;
    int exp_id;
    int q;
    logic [31:0] exp_d;
    cnt = '{0, 0, 0};
    pkt = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    yumi_auto = 1'b1;
    for (int cyc = 0; cyc < 100 && pkt < 6; cyc++) begin
      @(negedge clk);
      v = 3'b111;
      for (int s = 0; s < 3; s++) din[s*8 +: 8] = 8'((s << 4) | (cnt[s] & 15));
      #1;
      checks++;
      if ($countones(ready) > 1) begin
        failures++;
        $display("FAIL rr_onehot got ready=%b exp at most one bit", ready);
      end
      for (int s = 0; s < 3; s++) if (ready[s]) cnt[s]++;
      if (vo) begin
        exp_id = pkt % 3;
        q      = pkt / 3;
        for (int k = 0; k < 4; k++) exp_d[k*8 +: 8] = 8'((exp_id << 4) | (4 * q + k));
        checks++;
        if (id !== 2'(exp_id) || dout !== exp_d) begin
          failures++;
          $display("FAIL rr_pkt%0d got id=%0d data=%h exp id=%0d data=%h", pkt, id, dout, exp_id, exp_d);
        end
        pkt++;
      end
    end
    checks++;
    if (pkt !== 6) begin
      failures++;
      $display("FAIL rr_count got %0d packets exp 6", pkt);
    end
    @(negedge clk);
    v = '0;
    yumi_auto = 1'b0;
  endtask

  // Leaves the src2 packet presented for test_hold.
  task automatic test_stall();
    @(negedge clk);
    v = 3'b100;
    din = {8'hC0, 8'h00, 8'hEE};
    #1;
    checks++;
    if (ready !== 3'b100) begin
      failures++;
      $display("FAIL stall_grant got ready=%b exp 100", ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v = 3'b001;
      din = {8'h77, 8'h00, 8'hEE};
      #1;
      checks++;
      if (ready !== 3'b100) begin
        failures++;
        $display("FAIL stall_idle%0d got ready=%b exp 100", i, ready);
      end
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      v = 3'b101;
      din = {8'(8'hC0 + k), 8'h00, 8'hEE};
      #1;
      checks++;
      if (ready !== 3'b100 || vo !== 1'b0) begin
        failures++;
        $display("FAIL stall_word%0d got ready=%b vo=%b exp ready=100 vo=0", k, ready, vo);
      end
    end
    @(negedge clk);
    v = '0;
    #1;
    checks++;
    if (vo !== 1'b1 || dout !== 32'hC3C2C1C0 || id !== 2'd2) begin
      failures++;
      $display("FAIL stall_pkt got vo=%b data=%h id=%0d exp vo=1 data=c3c2c1c0 id=2", vo, dout, id);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v = 3'b111;
      din = {8'h5A, 8'h5B, 8'h5C};
      #1;
      checks++;
      if (ready !== 3'b000 || vo !== 1'b1 || dout !== 32'hC3C2C1C0 || id !== 2'd2) begin
        failures++;
        $display("FAIL hold%0d got ready=%b vo=%b data=%h id=%0d exp ready=000 vo=1 data=c3c2c1c0 id=2",
                 i, ready, vo, dout, id);
      end
    end
    ack_main();
    v = '0;
    #1;
    checks++;
    if (vo !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got vo=%b exp 0", vo);
    end
  endtask

  task automatic test_single_word();
    @(negedge clk);
    v1 = 1'b1;
    d1 = 8'h05;
    #1;
    checks++;
    if (r1 !== 1'b1 || vo1 !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got ready=%b vo=%b exp ready=1 vo=0", r1, vo1);
    end
    @(negedge clk);
    v1 = 1'b0;
    d1 = 8'hFF;
    #1;
    checks++;
    if (vo1 !== 1'b1 || do1 !== 8'h05 || id1 !== 1'b0 || r1 !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got vo=%b data=%h id=%0d ready=%b exp vo=1 data=05 id=0 ready=0",
               vo1, do1, id1, r1);
    end
    yumi1 = 1'b1;
    @(negedge clk);
    yumi1 = 1'b0;
    v1 = 1'b1;
    d1 = 8'h06;
    #1;
    checks++;
    if (vo1 !== 1'b0 || r1 !== 1'b1) begin
      failures++;
      $display("FAIL single_idle got vo=%b ready=%b exp vo=0 ready=1", vo1, r1);
    end
    @(negedge clk);
    v1 = 1'b0;
    yumi1 = 1'b1;
    @(negedge clk);
    yumi1 = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v = 3'b010;
      din = {8'h00, 8'(8'h11 + k), 8'h00};
    end
    @(negedge clk);
    v = 3'b111;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 3'b000 || vo !== 1'b0) begin
      failures++;
      $display("FAIL areset_quiet got ready=%b vo=%b exp ready=000 vo=0", ready, vo);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      v = 3'b111;
      for (int s = 0; s < 3; s++) din[s*8 +: 8] = 8'((s << 4) | (8 + k));
      #1;
      checks++;
      if (ready !== 3'b001) begin
        failures++;
        $display("FAIL areset_word%0d got ready=%b exp 001", k, ready);
      end
    end
    @(negedge clk);
    v = '0;
    #1;
    checks++;
    if (vo !== 1'b1 || dout !== 32'h0B0A0908 || id !== 2'd0) begin
      failures++;
      $display("FAIL areset_pkt got vo=%b data=%h id=%0d exp vo=1 data=0b0a0908 id=0", vo, dout, id);
    end
    ack_main();
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_stall();
    test_hold();
    test_single_word();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
